// File: rtl/uart_tx_if.sv
// Byte push port of the UART transmitter: valid/ready handshake with one data byte.
// The sender drives valid/data and holds them until ready is seen at a rising edge.
interface uart_tx_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;

  modport master (output tx_valid, output tx_data, input  tx_ready);
  modport slave  (input  tx_valid, input  tx_data, output tx_ready);
endinterface

// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter: byte FIFO in front of a start/data/stop
// serialiser with a baud divisor derived from the system clock frequency.
module uart_tx #(
  parameter int CLK_FREQ_MHZ   = 50,
  parameter int UART_BAUD_RATE = 115200,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  uart_tx_if.slave                      tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          uart_txd
);

  localparam int DIV = (CLK_FREQ_MHZ * 1000000) / UART_BAUD_RATE;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] DIV_M1   = CW'(DIV - 1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  // ---------------- FIFO ----------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop, non_empty;

  // Ready and emptiness come from the registered count only, so a byte pushed
  // into an empty FIFO is never popped in the same cycle.
  assign tx.tx_ready = (count != FULL_CNT);
  assign non_empty   = (count != '0);
  assign push        = tx.tx_valid && tx.tx_ready;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx.tx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------- serialiser ----------------
  state_t        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d;
  logic          wrap;

  assign wrap = (baud_q == DIV_M1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    pop     = 1'b0;

    if (state_q != S_IDLE) baud_d = wrap ? '0 : baud_q + CW'(1);

    case (state_q)
      S_IDLE: begin
        if (non_empty) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr];
          baud_d  = '0;
          idx_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (wrap) begin
          idx_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (wrap) begin
          shift_d = {1'b0, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        // Chain straight into the next start bit when more bytes are queued.
        if (wrap) begin
          if (non_empty) begin
            pop     = 1'b1;
            shift_d = mem[rd_ptr];
            idx_d   = '0;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Line level is computed from the next state and registered, so the pin never glitches.
    case (state_d)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  assign uart_txd   = txd_q;
  assign fifo_count = count;
  assign tx_busy    = non_empty || (state_q != S_IDLE);

endmodule
